regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
// - Parametrised successor to the processor register file: DEPTH x WIDTH architectural registers, NUM_READ read ports.
// - Two write ports: WB (pipeline writeback) and LL (long-latency mult/div completion).
// - Per-register busy scoreboard: set at LL issue, cleared at LL completion; flags feed decode stall logic.
// - Fixed tap outputs for game I/O logic plus one externally loaded register.
// PARAMETERS
// - WIDTH     32  register data width
// - DEPTH     32  number of registers (power of 2); ADDR_W = $clog2(DEPTH)
// - NUM_READ  2   number of independent read ports (1..4)
// - TAP0_IDX  16  register driven on tap_out0
// - TAP1_IDX  17  register driven on tap_out1
// - EXT_IDX   20  register loaded from ext_data when ext_we=1
// PORTS
// - clock             in  1                 single clock, rising edge
// - ctrl_reset        in  1                 asynchronous, active-high reset
// - ctrl_readReg      in  NUM_READ*ADDR_W   packed read addresses; port i = [i*ADDR_W +: ADDR_W]
// - data_readReg      out NUM_READ*WIDTH    packed read data, combinational
// - busy_read         out NUM_READ          busy bit of each addressed register
// - wb_we / wb_addr / wb_data   in 1/ADDR_W/WIDTH  writeback write port
// - ll_set / ll_set_addr        in 1/ADDR_W        mark register busy (LL op issued)
// - ll_we / ll_addr / ll_data   in 1/ADDR_W/WIDTH  LL completion write; clears busy
// - ext_we / ext_data           in 1/WIDTH         load register EXT_IDX
// - tap_out0, tap_out1          out WIDTH          registers TAP0_IDX / TAP1_IDX (unbypassed)
// BEHAVIOUR
// - Reset (async, any time, incl. mid-LL-op): all registers 0, all busy 0; outputs reflect 0 immediately.
// - Register 0: always reads 0. All writes to it are ignored. ll_set to it is ignored, so it is never busy.
// - Writes take effect on the rising edge. Priority for one register in the same cycle: wb > ll > ext.
// - Losing writes are dropped silently.
// - ll_we to addr A always clears busy[A], even when wb wins the data write.
// - ll_set and ll_we to the same A in one cycle: busy[A] stays 1, because set wins; this covers back-to-back LL ops.
// - ll_set to an already-busy register leaves it busy. There is no counter; one outstanding LL op per register.
// - Reads are combinational, zero latency. Any number of ports may address the same register.
// - busy_read[i] = busy[ctrl_readReg[i]] as registered; no same-cycle bypass of set/clear.
// - wb_we/ll_we with an out-of-range address cannot occur, because DEPTH is a power of 2.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: a read of A in the cycle A is written returns the winning write data (same priority).
//   In that case busy_read[i] is also forced 0 if ll_we to A is the active writer.
// - REGFILE_BYPASS_EN undefined: reads return the pre-edge stored value; new data is visible the next cycle.
// - Taps and register 0 are never bypassed.
// STRUCTURE
// - regfile_pkg: ADDR_W function, default parameter localparams, typedef for packed read-port bundles.
// - Sub-module regfile_rd_port (one per read port, generate loop): address mux, optional bypass, busy select.
// - Top level holds storage, write-priority logic and scoreboard.
// TESTING
// - Reset mid-run: write r5=0xDEADBEEF, set busy r6, assert ctrl_reset between edges -> r5 reads 0 and busy_read 0 immediately.
// - wb write r0=0x1234 and ll_set r0 -> r0 reads 0, busy 0; tap outputs unchanged.
// - Same-cycle wb r7=0xAAAA0000, ll r7=0x5555 with r7 busy -> r7=0xAAAA0000 next cycle, busy[r7]=0.
// - ll_set r9 at cycle 1, ll_we r9=0x42 at cycle 5 -> busy_read=1 on cycles 2..5, 0 from cycle 6, data 0x42.
// - Back-to-back: ll_we r9 with ll_set r9 in the same cycle -> busy stays 1.
// - Bypass: wb r3=0x77 while port1 reads r3 -> 0x77 same cycle with REGFILE_BYPASS_EN, old value without.
// - ext_we=1, ext_data=0x10 plus wb to r20=0x20 -> r20=0x20. Then ext only -> r20=0x10. Write r16=0xFF -> tap_out0=0xFF next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
// Optional read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_READ = 2;
  localparam int DEF_TAP0_IDX = 16;
  localparam int DEF_TAP1_IDX = 17;
  localparam int DEF_EXT_IDX  = 20;

  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);

  typedef logic [DEF_NUM_READ*DEF_ADDR_W-1:0] rd_addr_bundle_t;
  typedef logic [DEF_NUM_READ*DEF_WIDTH-1:0]  rd_data_bundle_t;
  typedef logic [DEF_NUM_READ-1:0]            rd_busy_bundle_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register select, busy select and, when
// REGFILE_BYPASS_EN is defined, same-cycle forwarding of the winning write.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
`ifdef REGFILE_BYPASS_EN
  parameter int EXT_IDX = DEF_EXT_IDX,
`endif
  parameter int ADDR_W  = addr_w(DEPTH)
)(
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]             busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [WIDTH-1:0]             wb_data,
  input  logic                         ll_we,
  input  logic [ADDR_W-1:0]            ll_addr,
  input  logic [WIDTH-1:0]             ll_data,
  input  logic                         ext_we,
  input  logic [WIDTH-1:0]             ext_data,
`endif
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_busy
);

  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (rd_addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // Forward whichever write will win at the coming edge (wb > ll > ext).
    else if (wb_we && (wb_addr == rd_addr)) begin
      rd_data = wb_data;
    end else if (ll_we && (ll_addr == rd_addr)) begin
      rd_data = ll_data;
      rd_busy = 1'b0;
    end else if (ext_we && (rd_addr == ADDR_W'(EXT_IDX))) begin
      rd_data = ext_data;
    end
`endif
  end

endmodule

// File: rtl/regfile_param.sv
// Register file with WB/LL/external write ports, busy scoreboard and tap outputs.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_READ = DEF_NUM_READ,
  parameter int TAP0_IDX = DEF_TAP0_IDX,
  parameter int TAP1_IDX = DEF_TAP1_IDX,
  parameter int EXT_IDX  = DEF_EXT_IDX,
  localparam int ADDR_W  = addr_w(DEPTH)
)(
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg,
  output logic [NUM_READ*WIDTH-1:0]    data_readReg,
  output logic [NUM_READ-1:0]          busy_read,
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [WIDTH-1:0]             wb_data,
  input  logic                         ll_set,
  input  logic [ADDR_W-1:0]            ll_set_addr,
  input  logic                         ll_we,
  input  logic [ADDR_W-1:0]            ll_addr,
  input  logic [WIDTH-1:0]             ll_data,
  input  logic                         ext_we,
  input  logic [WIDTH-1:0]             ext_data,
  output logic [WIDTH-1:0]             tap_out0,
  output logic [WIDTH-1:0]             tap_out1
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;

  // Register 0 is left out of both loops so it stays zero and never busy.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wb_we && (wb_addr == ADDR_W'(i))) begin
          regs[i] <= wb_data;
        end else if (ll_we && (ll_addr == ADDR_W'(i))) begin
          regs[i] <= ll_data;
        end else if (ext_we && (i == EXT_IDX)) begin
          regs[i] <= ext_data;
        end

        // A new issue in the same cycle as a completion keeps the register busy.
        if (ll_set && (ll_set_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (ll_we && (ll_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    regfile_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
`ifdef REGFILE_BYPASS_EN
      .EXT_IDX (EXT_IDX),
`endif
      .ADDR_W  (ADDR_W)
    ) u_rd (
      .rd_addr  (ctrl_readReg[g*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .busy     (busy),
`ifdef REGFILE_BYPASS_EN
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .ll_we    (ll_we),
      .ll_addr  (ll_addr),
      .ll_data  (ll_data),
      .ext_we   (ext_we),
      .ext_data (ext_data),
`endif
      .rd_data  (data_readReg[g*WIDTH +: WIDTH]),
      .rd_busy  (busy_read[g])
    );
  end

  assign tap_out0 = regs[TAP0_IDX];
  assign tap_out1 = regs[TAP1_IDX];

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param with a behavioural array model and
// directed literal checks of reset, r0, priority, scoreboard and taps.
module tb_regfile_param;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 32;
  localparam int NUM_READ = 2;
  localparam int AW       = 5;
  localparam int TAP0     = 16;
  localparam int TAP1     = 17;
  localparam int EXTI     = 20;

  logic                      clock = 1'b0;
  logic                      ctrl_reset;
  logic [NUM_READ*AW-1:0]    ctrl_readReg;
  logic [NUM_READ*WIDTH-1:0] data_readReg;
  logic [NUM_READ-1:0]       busy_read;
  logic                      wb_we;
  logic [AW-1:0]             wb_addr;
  logic [WIDTH-1:0]          wb_data;
  logic                      ll_set;
  logic [AW-1:0]             ll_set_addr;
  logic                      ll_we;
  logic [AW-1:0]             ll_addr;
  logic [WIDTH-1:0]          ll_data;
  logic                      ext_we;
  logic [WIDTH-1:0]          ext_data;
  logic [WIDTH-1:0]          tap_out0;
  logic [WIDTH-1:0]          tap_out1;

  regfile_param dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .ctrl_readReg (ctrl_readReg),
    .data_readReg (data_readReg),
    .busy_read    (busy_read),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ll_set       (ll_set),
    .ll_set_addr  (ll_set_addr),
    .ll_we        (ll_we),
    .ll_addr      (ll_addr),
    .ll_data      (ll_data),
    .ext_we       (ext_we),
    .ext_data     (ext_data),
    .tap_out0     (tap_out0),
    .tap_out1     (tap_out1)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [WIDTH-1:0] m_regs [DEPTH];
  logic             m_busy [DEPTH];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model: apply writes lowest priority first so the highest one lands last.
  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (ext_we) m_regs[EXTI] = ext_data;
      if (ll_we)  m_regs[ll_addr] = ll_data;
      if (wb_we)  m_regs[wb_addr] = wb_data;
      m_regs[0] = '0;
      if (ll_we)  m_busy[ll_addr] = 1'b0;
      if (ll_set) m_busy[ll_set_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] a);
    logic [WIDTH-1:0] d;
    d = (a == 0) ? '0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      if (ext_we && a == AW'(EXTI)) d = ext_data;
      if (ll_we && ll_addr == a)    d = ll_data;
      if (wb_we && wb_addr == a)    d = wb_data;
    end
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (ll_we && ll_addr == a && !(wb_we && wb_addr == a)) b = 1'b0;
`endif
    return b;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < NUM_READ; i++) begin
        check($sformatf("rd%0d_data", i), data_readReg[i*WIDTH +: WIDTH],
              exp_data(ctrl_readReg[i*AW +: AW]));
        check($sformatf("rd%0d_busy", i), WIDTH'(busy_read[i]),
              WIDTH'(exp_busy(ctrl_readReg[i*AW +: AW])));
      end
      check("tap0", tap_out0, m_regs[TAP0]);
      check("tap1", tap_out1, m_regs[TAP1]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; ll_set = 1'b0; ll_we = 1'b0; ext_we = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    ctrl_readReg[p*AW +: AW] = a;
  endtask

  function automatic logic [WIDTH-1:0] rd(input int p);
    return data_readReg[p*WIDTH +: WIDTH];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0:       a = AW'($urandom_range(0, DEPTH - 1));
      1:       a = AW'(($urandom_range(0, 2) == 0) ? TAP0 :
                       ($urandom_range(0, 1) == 0) ? TAP1 : EXTI);
      default: a = AW'($urandom_range(0, 7));
    endcase
    return a;
  endfunction

  initial begin
    ctrl_reset   = 1'b0;
    ctrl_readReg = '0;
    wb_addr = '0; wb_data = '0; ll_set_addr = '0;
    ll_addr = '0; ll_data = '0; ext_data = '0;
    idle();
    #1 ctrl_reset = 1'b1;
    #1 cmp_en = 1'b1;
    set_rd(0, 5); set_rd(1, 16);
    #1;
    check("reset_rd0", rd(0), 32'h0);
    check("reset_busy0", WIDTH'(busy_read[0]), 32'h0);
    check("reset_tap0", tap_out0, 32'h0);
    tick();
    ctrl_reset = 1'b0;

    // Asynchronous reset between edges
    wb_we = 1'b1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    tick(); idle();
    ll_set = 1'b1; ll_set_addr = 6;
    tick(); idle();
    set_rd(0, 5); set_rd(1, 6);
    #1;
    check("pre_rst_r5", rd(0), 32'hDEADBEEF);
    check("pre_rst_busy6", WIDTH'(busy_read[1]), 32'h1);
    ctrl_reset = 1'b1;
    #1;
    check("rst_r5", rd(0), 32'h0);
    check("rst_busy6", WIDTH'(busy_read[1]), 32'h0);
    ctrl_reset = 1'b0;

    // Taps
    wb_we = 1'b1; wb_addr = 16; wb_data = 32'hFF;
    tick(); idle();
    check("tap0_ff", tap_out0, 32'hFF);
    wb_we = 1'b1; wb_addr = 17; wb_data = 32'hABCD;
    tick(); idle();
    check("tap1_abcd", tap_out1, 32'hABCD);

    // Register 0 ignores writes and busy marking
    wb_we = 1'b1; wb_addr = 0; wb_data = 32'h1234;
    ll_set = 1'b1; ll_set_addr = 0;
    tick(); idle();
    set_rd(0, 0);
    #1;
    check("r0_data", rd(0), 32'h0);
    check("r0_busy", WIDTH'(busy_read[0]), 32'h0);
    check("r0_tap0", tap_out0, 32'hFF);
    check("r0_tap1", tap_out1, 32'hABCD);

    // wb beats ll on data, ll still clears busy
    ll_set = 1'b1; ll_set_addr = 7;
    tick(); idle();
    wb_we = 1'b1; wb_addr = 7; wb_data = 32'hAAAA0000;
    ll_we = 1'b1; ll_addr = 7; ll_data = 32'h5555;
    tick(); idle();
    set_rd(0, 7);
    #1;
    check("r7_data", rd(0), 32'hAAAA0000);
    check("r7_busy", WIDTH'(busy_read[0]), 32'h0);

    // LL op lifetime on r9
    ll_set = 1'b1; ll_set_addr = 9;
    tick(); idle();
    set_rd(0, 9);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("r9_busy_c%0d", c + 2), WIDTH'(busy_read[0]), 32'h1);
      tick();
    end
    ll_we = 1'b1; ll_addr = 9; ll_data = 32'h42;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_busy_c5", WIDTH'(busy_read[0]), 32'h0);
`else
    check("r9_busy_c5", WIDTH'(busy_read[0]), 32'h1);
`endif
    tick(); idle();
    #1;
    check("r9_busy_c6", WIDTH'(busy_read[0]), 32'h0);
    check("r9_data", rd(0), 32'h42);

    // Back-to-back LL ops: set wins over clear
    ll_set = 1'b1; ll_set_addr = 9;
    tick(); idle();
    ll_set = 1'b1; ll_set_addr = 9;
    ll_we = 1'b1; ll_addr = 9; ll_data = 32'h43;
    tick(); idle();
    #1;
    check("b2b_busy", WIDTH'(busy_read[0]), 32'h1);
    check("b2b_data", rd(0), 32'h43);
    ll_we = 1'b1; ll_addr = 9; ll_data = 32'h44;
    tick(); idle();

    // Same-cycle read of a register being written
    wb_we = 1'b1; wb_addr = 3; wb_data = 32'h11;
    tick(); idle();
    wb_we = 1'b1; wb_addr = 3; wb_data = 32'h77;
    set_rd(1, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_r3", rd(1), 32'h77);
`else
    check("byp_r3", rd(1), 32'h11);
`endif
    tick(); idle();
    #1 check("r3_after", rd(1), 32'h77);

    // External load vs writeback
    ext_we = 1'b1; ext_data = 32'h10;
    wb_we = 1'b1; wb_addr = 20; wb_data = 32'h20;
    tick(); idle();
    set_rd(0, 20);
    #1 check("r20_wb_wins", rd(0), 32'h20);
    ext_we = 1'b1; ext_data = 32'h10;
    tick(); idle();
    #1 check("r20_ext", rd(0), 32'h10);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        ctrl_reset = 1'b1;
        #1 ctrl_reset = 1'b0;
      end
      wb_we       = ($urandom_range(0, 2) == 0);
      wb_addr     = rand_addr();
      wb_data     = $urandom;
      ll_set      = ($urandom_range(0, 3) == 0);
      ll_set_addr = rand_addr();
      ll_we       = ($urandom_range(0, 3) == 0);
      ll_addr     = rand_addr();
      ll_data     = $urandom;
      ext_we      = ($urandom_range(0, 3) == 0);
      ext_data    = $urandom;
      for (int p = 0; p < NUM_READ; p++) set_rd(p, rand_addr());
    end
    tick(); idle();
    @(negedge clock);
    #1 cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
